// File: rtl/mem_arbiter_pkg.sv
// Shared sizes and FSM encoding for the instruction/data cache memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned WORD_SIZE        = 32;
  localparam int unsigned BLOCK_SIZE       = 256;
  localparam int unsigned CACHE_OFFSET_LEN = 5;

  // Requester index: bit 0 of the request vector is the icache, bit 1 the dcache.
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_XFER = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: picks a single requester, favouring the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // One-hot grant; on a tie the port that was not served last wins.
  always_comb begin
    grant = '0;
    if (req == 2'b11) begin
      grant = (last == 1'b1) ? 2'b01 : 2'b10;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the block-wide backing memory between the icache refill path and the
// dcache refill/write-back path, one fixed-latency transfer at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned AW      = WORD_SIZE,
  parameter int unsigned BW      = BLOCK_SIZE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [BW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [BW-1:0] d_wdata,
  output logic          d_ack,
  output logic [BW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [BW-1:0] mem_wdata,
  input  logic [BW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned   CW         = $clog2(MEM_LAT + 1);
  localparam logic [AW-1:0] ALIGN_MASK = {{(AW - CACHE_OFFSET_LEN){1'b1}},
                                          {CACHE_OFFSET_LEN{1'b0}}};

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            owner;
  logic            last;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [BW-1:0]   wdata_q;
  logic [BW-1:0]   i_rdata_q;
  logic [BW-1:0]   d_rdata_q;
  logic [1:0]      grant;
  logic            xfer_done;

  rr_arb2 u_arb (
    .req   ({d_req, i_req}),
    .last  (last),
    .grant (grant)
  );

  assign xfer_done = (state == ST_XFER) && (cnt == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: grant from IDLE, count out XFER, one RESP cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|grant)   state_nxt = ST_XFER;
      ST_XFER: if (xfer_done) state_nxt = ST_RESP;
      ST_RESP:               state_nxt = ST_IDLE;
      default:               state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's transfer on grant and run the latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      owner   <= PORT_I;
      last    <= PORT_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (state == ST_IDLE && (|grant)) begin
        owner  <= grant[1];
        last   <= grant[1];
        we_q   <= grant[1] & d_we;
        addr_q <= (grant[1] ? d_addr : i_addr) & ALIGN_MASK;
        if (grant[1]) wdata_q <= d_wdata;
        cnt    <= CW'(MEM_LAT - 1);
      end else if (state == ST_XFER && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Capture read data into the winner's register at the edge leaving XFER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (xfer_done && !we_q) begin
      if (owner == PORT_D) d_rdata_q <= mem_rdata;
      else                 i_rdata_q <= mem_rdata;
    end
  end

  // Outputs decoded from the state register so reset clears them asynchronously.
  always_comb begin
    mem_rd = (state == ST_XFER) && !we_q;
    mem_wr = (state == ST_XFER) &&  we_q;
    i_ack  = (state == ST_RESP) && (owner == PORT_I);
    d_ack  = (state == ST_RESP) && (owner == PORT_D);
    busy   = (state != ST_IDLE);
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
